// File: rtl/coalesce_sequencer_pkg.sv
// Shared sizing defaults and FSM state encodings for the memory coalescing path.
package coalesce_sequencer_pkg;

    localparam int DEF_SIZE_CORE              = 32;
    localparam int DEF_SIZE_CORE_LOG          = 5;
    localparam int DEF_SIZE_ADDR              = 32;
    localparam int DEF_SIZE_SEGMENT_BYTES_LOG = 6;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SELECT = 3'd1;
    localparam logic [2:0] ST_ISSUE  = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

endpackage

// File: rtl/coalesce_sequencer_lane_first_one.sv
// Combinational lowest-index priority encoder over a lane mask; index is 0 for an empty mask.
module lane_first_one
    import coalesce_sequencer_pkg::*;
#(
    parameter int SIZE_CORE     = DEF_SIZE_CORE,
    parameter int SIZE_CORE_LOG = DEF_SIZE_CORE_LOG
) (
    input  logic [SIZE_CORE-1:0]     i_mask,
    output logic [SIZE_CORE_LOG-1:0] o_index
);

    logic w_found;

    always_comb begin
        o_index = '0;
        w_found = 1'b0;
        for (int unsigned i = 0; i < SIZE_CORE; i++) begin
            if (!w_found && i_mask[i]) begin
                o_index = SIZE_CORE_LOG'(i);
                w_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/coalesce_sequencer.sv
// Walks a warp request one memory segment at a time, retiring served lanes until none remain.
module coalesce_sequencer
    import coalesce_sequencer_pkg::*;
#(
    parameter int SIZE_CORE              = DEF_SIZE_CORE,
    parameter int SIZE_CORE_LOG          = DEF_SIZE_CORE_LOG,
    parameter int SIZE_ADDR              = DEF_SIZE_ADDR,
    parameter int SIZE_SEGMENT_BYTES_LOG = DEF_SIZE_SEGMENT_BYTES_LOG
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [SIZE_CORE-1:0]     req_mask,
    input  logic                     req_we,
    output logic [SIZE_CORE_LOG-1:0] fa_first_one,
    output logic [SIZE_CORE-1:0]     fa_mask,
    input  logic [SIZE_ADDR-1:0]     fa_addr,
    input  logic [SIZE_CORE-1:0]     fa_outmask,
    output logic                     mem_valid,
    input  logic                     mem_ready,
    output logic [SIZE_ADDR-1:0]     mem_addr,
    output logic [SIZE_CORE-1:0]     mem_lanes,
    output logic                     mem_we,
    input  logic                     mem_resp_valid,
    output logic                     done,
    output logic [SIZE_CORE_LOG:0]   txn_count
);

    localparam logic [SIZE_CORE_LOG:0] TXN_MAX = (SIZE_CORE_LOG + 1)'(SIZE_CORE);

    logic [2:0]                 r_state;
    logic [SIZE_CORE-1:0]       r_pending;
    logic                       r_we;
    logic [SIZE_ADDR-1:0]       r_mem_addr;
    logic [SIZE_CORE-1:0]       r_mem_lanes;
    logic [SIZE_CORE_LOG:0]     r_txn_count;

    logic [SIZE_CORE_LOG-1:0]   w_first_one;
    logic [SIZE_CORE-1:0]       w_first_onehot;
    logic [SIZE_CORE-1:0]       w_sel_lanes;
    logic [SIZE_CORE-1:0]       w_pending_next;
    logic [SIZE_ADDR-1:0]       w_seg_base;
    logic                       w_unused_addr_lo;

    lane_first_one #(
        .SIZE_CORE     (SIZE_CORE),
        .SIZE_CORE_LOG (SIZE_CORE_LOG)
    ) u_first_one (
        .i_mask  (r_pending),
        .o_index (w_first_one)
    );

    always_comb begin
        w_first_onehot   = SIZE_CORE'(1) << w_first_one;
        w_sel_lanes      = fa_outmask & r_pending;
        w_pending_next   = r_pending & ~r_mem_lanes;
        w_seg_base       = {fa_addr[SIZE_ADDR-1:SIZE_SEGMENT_BYTES_LOG], {SIZE_SEGMENT_BYTES_LOG{1'b0}}};
        w_unused_addr_lo = ^fa_addr[SIZE_SEGMENT_BYTES_LOG-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_pending   <= '0;
            r_we        <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_lanes <= '0;
            r_txn_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_pending   <= req_mask;
                        r_we        <= req_we;
                        r_txn_count <= '0;
                        r_state     <= (|req_mask) ? ST_SELECT : ST_DONE;
                    end
                end
                ST_SELECT: begin
                    r_mem_addr  <= w_seg_base;
                    // An empty intersection would stall forever; serve the first pending lane alone.
                    r_mem_lanes <= (|w_sel_lanes) ? w_sel_lanes : w_first_onehot;
                    r_state     <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (mem_ready) begin
                        if (r_txn_count != TXN_MAX) begin
                            r_txn_count <= r_txn_count + 1'b1;
                        end
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_resp_valid) begin
                        r_pending <= w_pending_next;
                        r_state   <= (|w_pending_next) ? ST_SELECT : ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        req_ready    = (r_state == ST_IDLE);
        mem_valid    = (r_state == ST_ISSUE);
        done         = (r_state == ST_DONE);
        fa_mask      = r_pending;
        fa_first_one = w_first_one;
        mem_addr     = r_mem_addr;
        mem_lanes    = r_mem_lanes;
        mem_we       = r_we;
        txn_count    = r_txn_count;
    end

endmodule

// File: tb/tb_coalesce_sequencer.sv
// Directed bench for coalesce_sequencer: a lane-address selector stub, a memory responder, and a segment-level reference model.
module tb_coalesce_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_mask = '0;
    logic        req_we = 1'b0;
    logic [4:0]  fa_first_one;
    logic [31:0] fa_mask;
    logic [31:0] fa_addr;
    logic [31:0] fa_outmask;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_lanes;
    logic        mem_we;
    logic        mem_resp_valid = 1'b0;
    logic        done;
    logic [5:0]  txn_count;

    always #5 clk = ~clk;

    coalesce_sequencer #(
        .SIZE_CORE              (32),
        .SIZE_CORE_LOG          (5),
        .SIZE_ADDR              (32),
        .SIZE_SEGMENT_BYTES_LOG (6)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_mask       (req_mask),
        .req_we         (req_we),
        .fa_first_one   (fa_first_one),
        .fa_mask        (fa_mask),
        .fa_addr        (fa_addr),
        .fa_outmask     (fa_outmask),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_addr       (mem_addr),
        .mem_lanes      (mem_lanes),
        .mem_we         (mem_we),
        .mem_resp_valid (mem_resp_valid),
        .done           (done),
        .txn_count      (txn_count)
    );

    // Lane address table and selector stub (same-segment lanes over all 32 lanes, pending or not).
    logic [31:0] addr_tab [32];
    bit          sel_zero = 1'b0;
    logic [25:0] sel_seg;

    always_comb begin
        sel_seg    = addr_tab[fa_first_one][31:6];
        fa_addr    = addr_tab[fa_first_one];
        fa_outmask = '0;
        if (!sel_zero) begin
            for (int i = 0; i < 32; i++) begin
                if (addr_tab[i][31:6] == sel_seg) fa_outmask[i] = 1'b1;
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [31:0] m);
        for (int i = 0; i < 32; i++) if (m[i]) return i;
        return 0;
    endfunction

    // Expected transactions for a request, derived from segment grouping of the address table.
    logic [31:0] exq_addr[$];
    logic [31:0] exq_lanes[$];
    logic        exp_we;
    logic [31:0] log_addr[$];
    logic [31:0] log_lanes[$];

    task automatic build_exp(input logic [31:0] mask);
        logic [31:0] p;
        logic [31:0] l;
        int f;
        exq_addr.delete();
        exq_lanes.delete();
        p = mask;
        while (p != 0) begin
            f = lowest(p);
            l = '0;
            if (sel_zero) l[f] = 1'b1;
            else
                for (int i = 0; i < 32; i++)
                    if (p[i] && addr_tab[i][31:6] == addr_tab[f][31:6]) l[i] = 1'b1;
            exq_addr.push_back({addr_tab[f][31:6], 6'b0});
            exq_lanes.push_back(l);
            p = p & ~l;
        end
    endtask

    // Reference model state, advanced once per cycle by the compare process.
    bit          chk_en = 1'b0;
    bit          busy = 1'b0;
    bit          done_flag = 1'b0;
    bit          outstanding = 1'b0;
    bit          rst_prev = 1'b1;
    int          issue_in = -1;
    int          txn_m = 0;
    int          cyc = 0;
    int          last_done_cyc = -1;
    logic [31:0] pend_m = '0;
    logic [31:0] out_lanes = '0;

    always @(negedge clk) begin : compare
        bit hs;
        bit acc;
        if (chk_en) begin
            cyc++;
            if (rst_prev) begin
                chk("reset_mem_addr", 64'(mem_addr), 64'd0);
                chk("reset_mem_lanes", 64'(mem_lanes), 64'd0);
                chk("reset_mem_we", 64'(mem_we), 64'd0);
            end
            chk("req_ready", 64'(req_ready), 64'(!busy));
            chk("done", 64'(done), 64'(done_flag));
            chk("mem_valid", 64'(mem_valid), 64'(issue_in == 0));
            chk("txn_count", 64'(txn_count), 64'(txn_m));
            chk("fa_mask", 64'(fa_mask), 64'(pend_m));
            chk("fa_first_one", 64'(fa_first_one), 64'(lowest(pend_m)));
            if (mem_valid) begin
                if (exq_addr.size() == 0) begin
                    chk("unexpected_txn_lanes", 64'(mem_lanes), 64'd0);
                end else begin
                    chk("mem_addr", 64'(mem_addr), 64'(exq_addr[0]));
                    chk("mem_lanes", 64'(mem_lanes), 64'(exq_lanes[0]));
                    chk("mem_we", 64'(mem_we), 64'(exp_we));
                end
            end
            if (done) last_done_cyc = cyc;

            hs  = mem_valid && mem_ready && (issue_in == 0) && (exq_addr.size() != 0);
            acc = req_valid && !busy;
            if (done_flag) busy = 1'b0;
            done_flag = 1'b0;
            if (issue_in == 0 && hs) issue_in = -1;
            else if (issue_in > 0) issue_in--;
            if (outstanding && mem_resp_valid) begin
                pend_m      = pend_m & ~out_lanes;
                outstanding = 1'b0;
                if (pend_m == 0) done_flag = 1'b1;
                else issue_in = 1;
            end
            if (hs) begin
                outstanding = 1'b1;
                out_lanes   = exq_lanes[0];
                log_addr.push_back(exq_addr[0]);
                log_lanes.push_back(exq_lanes[0]);
                void'(exq_addr.pop_front());
                void'(exq_lanes.pop_front());
                txn_m++;
            end
            if (acc) begin
                busy   = 1'b1;
                pend_m = req_mask;
                txn_m  = 0;
                cyc    = 0;
                if (req_mask == 0) done_flag = 1'b1;
                else issue_in = 1;
            end
            if (!rst_n) begin
                busy = 1'b0; done_flag = 1'b0; outstanding = 1'b0;
                issue_in = -1; txn_m = 0; pend_m = '0;
                exq_addr.delete(); exq_lanes.delete();
                rst_prev = 1'b1;
            end else begin
                rst_prev = 1'b0;
            end
        end
    end

    task automatic layout_linear(input logic [31:0] base, input logic [31:0] stride);
        for (int i = 0; i < 32; i++) addr_tab[i] = base + stride * i;
    endtask

    task automatic layout_mixed();
        for (int i = 0; i < 32; i++) begin
            if (i < 4)      addr_tab[i] = 32'h2000 + 4 * i;
            else if (i < 8) addr_tab[i] = 32'h2040 + 4 * (i - 4);
            else            addr_tab[i] = 32'h3000 + 64 * i;
        end
    endtask

    // Issues one request and plays the memory side until done, stalling each transaction `stall` cycles.
    task automatic run(input logic [31:0] mask, input logic we, input int stall);
        bit v_prev;
        bit hs_prev;
        bit finished;
        int stall_cnt;
        build_exp(mask);
        exp_we = we;
        log_addr.delete();
        log_lanes.delete();
        @(posedge clk); #2;
        req_valid = 1'b1; req_mask = mask; req_we = we;
        @(posedge clk); #2;
        req_valid = 1'b0; req_mask = ~mask; req_we = ~we;
        v_prev = 1'b0; finished = 1'b0; stall_cnt = 0;
        for (int k = 0; k < 400 && !finished; k++) begin
            hs_prev = v_prev && mem_ready;
            if (hs_prev) stall_cnt = 0;
            mem_resp_valid = hs_prev;
            if (mem_valid && stall_cnt < stall) begin
                mem_ready      = 1'b0;
                mem_resp_valid = 1'b1;
                stall_cnt++;
            end else begin
                mem_ready = mem_valid;
            end
            v_prev = mem_valid;
            if (done) finished = 1'b1;
            @(posedge clk); #2;
        end
        mem_ready = 1'b0; mem_resp_valid = 1'b0;
        if (!finished) chk("done_timeout", 64'd0, 64'd1);
        @(posedge clk); #2;
    endtask

    initial begin
        layout_linear(32'h1000, 32'd2);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        chk_en = 1'b1;

        // Single segment
        run(32'hFFFF_FFFF, 1'b0, 0);
        chk("single_count", 64'(log_addr.size()), 64'd1);
        if (log_addr.size() == 1) begin
            chk("single_addr", 64'(log_addr[0]), 64'h1000);
            chk("single_lanes", 64'(log_lanes[0]), 64'hFFFF_FFFF);
        end
        chk("single_done_cyc", 64'(last_done_cyc), 64'd4);
        chk("single_txn_count", 64'(txn_count), 64'd1);

        // Fully scattered
        layout_linear(32'h1000, 32'd64);
        run(32'hFFFF_FFFF, 1'b1, 0);
        chk("scatter_count", 64'(log_addr.size()), 64'd32);
        if (log_addr.size() == 32) begin
            chk("scatter_lanes5", 64'(log_lanes[5]), 64'h20);
            chk("scatter_addr31", 64'(log_addr[31]), 64'h17C0);
        end
        chk("scatter_done_cyc", 64'(last_done_cyc), 64'd97);
        chk("scatter_txn_count", 64'(txn_count), 64'd32);

        // Mixed mask, lane 1 inactive but in segment 0x2000
        layout_mixed();
        run(32'h0000_00F5, 1'b0, 0);
        chk("mixed_count", 64'(log_addr.size()), 64'd2);
        if (log_addr.size() == 2) begin
            chk("mixed_addr0", 64'(log_addr[0]), 64'h2000);
            chk("mixed_lanes0", 64'(log_lanes[0]), 64'h5);
            chk("mixed_addr1", 64'(log_addr[1]), 64'h2040);
            chk("mixed_lanes1", 64'(log_lanes[1]), 64'hF0);
        end
        chk("mixed_done_cyc", 64'(last_done_cyc), 64'd7);

        // Backpressure: 5 stalled ISSUE cycles with spurious responses
        layout_linear(32'h1000, 32'd2);
        run(32'h0000_FFFF, 1'b1, 5);
        chk("bp_count", 64'(log_addr.size()), 64'd1);
        chk("bp_txn_count", 64'(txn_count), 64'd1);
        chk("bp_done_cyc", 64'(last_done_cyc), 64'd9);

        // Empty mask
        run(32'h0, 1'b0, 0);
        chk("empty_count", 64'(log_addr.size()), 64'd0);
        chk("empty_done_cyc", 64'(last_done_cyc), 64'd1);
        chk("empty_txn_count", 64'(txn_count), 64'd0);

        // Selector reports no same-segment lanes: first pending lane is forced
        sel_zero = 1'b1;
        run(32'h0000_0006, 1'b0, 0);
        chk("force_count", 64'(log_addr.size()), 64'd2);
        if (log_addr.size() == 2) begin
            chk("force_lanes0", 64'(log_lanes[0]), 64'h2);
            chk("force_lanes1", 64'(log_lanes[1]), 64'h4);
        end
        sel_zero = 1'b0;

        // Reset during WAIT, then a stale response
        layout_linear(32'h1000, 32'd64);
        build_exp(32'h3);
        exp_we = 1'b0;
        @(posedge clk); #2;
        req_valid = 1'b1; req_mask = 32'h3; req_we = 1'b0;
        @(posedge clk); #2;
        req_valid = 1'b0;
        for (int k = 0; k < 20 && !mem_valid; k++) begin
            @(posedge clk); #2;
        end
        chk("rst_reached_issue", 64'(mem_valid), 64'd1);
        mem_ready = 1'b1;
        @(posedge clk); #2;
        mem_ready = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_txn_count", 64'(txn_count), 64'd0);
        repeat (2) begin @(posedge clk); #2; end
        mem_resp_valid = 1'b1;
        @(posedge clk); #2;
        mem_resp_valid = 1'b0;
        repeat (2) begin @(posedge clk); #2; end
        chk("stale_resp_fa_mask", 64'(fa_mask), 64'd0);
        chk("stale_resp_done", 64'(done), 64'd0);

        // Normal operation after reset
        run(32'h0000_0001, 1'b1, 0);
        chk("post_rst_count", 64'(log_addr.size()), 64'd1);
        chk("post_rst_done_cyc", 64'(last_done_cyc), 64'd4);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
